// File: rtl/led_scan_controller.sv
// Scanning LED controller: debounced left/right buttons pick a scan mode that steps an 8-LED pattern.
// Optional BOUNCE mode is compiled in when LED_SCAN_BOUNCE_EN is defined.
module led_scan_controller #(
  parameter int unsigned MAIN_CLOCK_FREQ = 12_000_000,
  parameter int unsigned STEP_FREQ       = 4,
  parameter int unsigned DEBOUNCE_FREQ   = 8
) (
  input  logic       CLK_IN,
  input  logic       RST_N_IN,
  input  logic       BTN_LEFT_N_IN,
  input  logic       BTN_RIGHT_N_IN,
  output logic [7:0] LED_OUT,
  output logic [1:0] MODE_OUT,
  output logic       STEP_TICK_OUT
);

  localparam int unsigned STEP_COUNT     = MAIN_CLOCK_FREQ / STEP_FREQ;
  localparam int unsigned DEBOUNCE_COUNT = MAIN_CLOCK_FREQ / DEBOUNCE_FREQ;
  localparam int unsigned STEP_W = (STEP_COUNT > 1) ? $clog2(STEP_COUNT) : 1;
  localparam int unsigned DEB_W  = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
  localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(STEP_COUNT - 1);
  localparam logic [DEB_W-1:0]  DEB_RELOAD  = DEB_W'(DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {
    MODE_STOP   = 2'd0,
    MODE_LEFT   = 2'd1,
    MODE_RIGHT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  // Button vectors: bit 1 = left, bit 0 = right (active-low levels).
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        stable_q, stable_d;
  logic [1:0]        busy_q, busy_d;
  logic [DEB_W-1:0]  dcnt_q [2];
  logic [DEB_W-1:0]  dcnt_d [2];
  logic [1:0]        press;
  logic [STEP_W-1:0] step_q, step_d;
  logic              tick;
  logic [7:0]        led_q, led_d;
  mode_e             mode_q, mode_d;
`ifdef LED_SCAN_BOUNCE_EN
  logic              dir_left_q, dir_left_d;
`endif

  always_comb begin
    stable_d = stable_q;
    busy_d   = busy_q;
    dcnt_d   = dcnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (!busy_q[i]) begin
        if (sync2_q[i] != stable_q[i]) begin
          busy_d[i] = 1'b1;
          dcnt_d[i] = DEB_RELOAD;
        end
      end else if (sync2_q[i] == stable_q[i]) begin
        busy_d[i] = 1'b0;
      end else if (dcnt_q[i] == '0) begin
        stable_d[i] = sync2_q[i];
        busy_d[i]   = 1'b0;
      end else begin
        dcnt_d[i] = dcnt_q[i] - 1'b1;
      end
    end
    // Event fires in the cycle the stable level is about to fall, so the mode lands with it.
    press = stable_q & ~stable_d;
  end

  always_comb begin
    tick   = (step_q == '0);
    step_d = tick ? STEP_RELOAD : step_q - 1'b1;
  end

  always_comb begin
    mode_d = mode_q;
    unique case (press)
      2'b10:   mode_d = (mode_q == MODE_RIGHT) ? MODE_STOP : MODE_LEFT;
      2'b01:   mode_d = (mode_q == MODE_LEFT) ? MODE_STOP : MODE_RIGHT;
`ifdef LED_SCAN_BOUNCE_EN
      2'b11:   mode_d = (mode_q == MODE_BOUNCE) ? MODE_STOP : MODE_BOUNCE;
`endif
      default: mode_d = mode_q;
    endcase
  end

  always_comb begin
    led_d = led_q;
`ifdef LED_SCAN_BOUNCE_EN
    dir_left_d = dir_left_q;
`endif
    if (tick) begin
      case (mode_q)
        MODE_LEFT:  led_d = {led_q[6:0], led_q[7]};
        MODE_RIGHT: led_d = {led_q[0], led_q[7:1]};
`ifdef LED_SCAN_BOUNCE_EN
        MODE_BOUNCE: begin
          if (dir_left_q) begin
            if (led_q == 8'h80) begin
              dir_left_d = 1'b0;
              led_d      = 8'h40;
            end else begin
              led_d = led_q << 1;
            end
          end else begin
            if (led_q == 8'h01) begin
              dir_left_d = 1'b1;
              led_d      = 8'h02;
            end else begin
              led_d = led_q >> 1;
            end
          end
        end
`endif
        default: led_d = led_q;
      endcase
    end
`ifdef LED_SCAN_BOUNCE_EN
    // Entry wins over a same-cycle bounce turnaround, which used the old mode anyway.
    if (mode_d == MODE_BOUNCE && mode_q != MODE_BOUNCE) begin
      dir_left_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      busy_q   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        dcnt_q[i] <= '0;
      end
      step_q   <= STEP_RELOAD;
      led_q    <= 8'h01;
      mode_q   <= MODE_STOP;
`ifdef LED_SCAN_BOUNCE_EN
      dir_left_q <= 1'b1;
`endif
    end else begin
      sync1_q  <= {BTN_LEFT_N_IN, BTN_RIGHT_N_IN};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      busy_q   <= busy_d;
      dcnt_q   <= dcnt_d;
      step_q   <= step_d;
      led_q    <= led_d;
      mode_q   <= mode_d;
`ifdef LED_SCAN_BOUNCE_EN
      dir_left_q <= dir_left_d;
`endif
    end
  end

  assign LED_OUT       = led_q;
  assign MODE_OUT      = mode_q;
  assign STEP_TICK_OUT = tick;

endmodule
